// File: rtl/mfcc_frame_buffer.sv
// Double-buffered MFCC frame collector that replays whole frames over a valid/ready stream.
// Define MFCC_DELTA_EN to append saturated per-coefficient deltas to every output frame.
module mfcc_frame_buffer #(
    parameter int unsigned NUM_COEFFS     = 4,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FRAME_ID_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     mfcc_in,
    input  logic                      valid_in,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [FRAME_ID_WIDTH-1:0] out_frame_id,
    output logic                      overflow,
    input  logic                      clear_ovf
);

    localparam int unsigned IDX_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
`ifdef MFCC_DELTA_EN
    localparam int unsigned RD_LEN = 2 * NUM_COEFFS;
`else
    localparam int unsigned RD_LEN = NUM_COEFFS;
`endif
    localparam int unsigned RD_W = (RD_LEN > 1) ? $clog2(RD_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(NUM_COEFFS - 1);
    localparam logic [RD_W-1:0]  LAST_RD = RD_W'(RD_LEN - 1);

    typedef enum logic [0:0] {StIdle, StStream} rd_state_e;

    // Frame storage and bank bookkeeping
    logic [DATA_WIDTH-1:0]     mem_q     [2][NUM_COEFFS];
    logic [1:0]                full_q;
    logic [FRAME_ID_WIDTH-1:0] bank_id_q [2];

    // Write side
    logic                      in_valid_q;
    logic [DATA_WIDTH-1:0]     in_data_q;
    logic                      wr_bank_q;
    logic [IDX_W-1:0]          wr_idx_q;
    logic                      drop_q;
    logic [FRAME_ID_WIDTH-1:0] in_frame_id_q;

    // Read side
    rd_state_e                 state_q;
    logic                      rd_bank_q;
    logic [RD_W-1:0]           rd_idx_q;
    logic [RD_W-1:0]           rd_sel;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic                      rd_release;

    logic wr_first, wr_final, bank_free, wr_keep, wr_commit, wr_drop_start;

    // Final handshake of the frame currently on the output
    assign rd_release = (state_q == StStream) && out_ready && out_last;

    // A bank freed by this cycle's final handshake may be refilled immediately
    assign wr_first      = (wr_idx_q == '0);
    assign wr_final      = (wr_idx_q == LAST_WR);
    assign bank_free     = !full_q[wr_bank_q] || (rd_release && (rd_bank_q == wr_bank_q));
    assign wr_keep       = wr_first ? bank_free : !drop_q;
    assign wr_commit     = in_valid_q && wr_keep && wr_final;
    assign wr_drop_start = in_valid_q && wr_first && !bank_free;

    // Input register: gives the write decision a full cycle and sets the output latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_valid_q    <= 1'b0;
            in_data_q     <= '0;
            wr_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            drop_q        <= 1'b0;
            in_frame_id_q <= '0;
            overflow      <= 1'b0;
            bank_id_q[0]  <= '0;
            bank_id_q[1]  <= '0;
        end else begin
            in_valid_q <= valid_in;
            in_data_q  <= mfcc_in;
            if (in_valid_q) begin
                if (wr_first) begin
                    drop_q <= !bank_free;
                end
                if (wr_final) begin
                    wr_idx_q      <= '0;
                    in_frame_id_q <= in_frame_id_q + FRAME_ID_WIDTH'(1);
                end else begin
                    wr_idx_q <= wr_idx_q + IDX_W'(1);
                end
                if (wr_commit) begin
                    bank_id_q[wr_bank_q] <= in_frame_id_q;
                    wr_bank_q            <= ~wr_bank_q;
                end
            end
            if (wr_drop_start) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid_q && wr_keep) begin
            mem_q[wr_bank_q][wr_idx_q] <= in_data_q;
        end
    end

    // Set after clear so a same-bank release and commit leaves the bank full
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= '0;
        end else begin
            if (rd_release) begin
                full_q[rd_bank_q] <= 1'b0;
            end
            if (wr_commit) begin
                full_q[wr_bank_q] <= 1'b1;
            end
        end
    end

    // Index of the word to present after the next load
    assign rd_sel = (state_q == StIdle) ? '0 : rd_idx_q + RD_W'(1);

`ifdef MFCC_DELTA_EN
    logic [DATA_WIDTH-1:0] prev_q [NUM_COEFFS];

    function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] diff;
        diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
            sat_sub = diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sat_sub = diff[DATA_WIDTH-1:0];
        end
    endfunction

    always_comb begin
        rd_word = '0;
        if (rd_sel < RD_W'(NUM_COEFFS)) begin
            rd_word = mem_q[rd_bank_q][IDX_W'(rd_sel)];
        end else begin
            rd_word = sat_sub(mem_q[rd_bank_q][IDX_W'(rd_sel - RD_W'(NUM_COEFFS))],
                              prev_q[IDX_W'(rd_sel - RD_W'(NUM_COEFFS))]);
        end
    end

    // History follows released frames only, so dropped frames never reach it
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                prev_q[i] <= '0;
            end
        end else if (rd_release) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                prev_q[i] <= mem_q[rd_bank_q][i];
            end
        end
    end
`else
    always_comb begin
        rd_word = '0;
        rd_word = mem_q[rd_bank_q][IDX_W'(rd_sel)];
    end
`endif

    // Read FSM; every output is registered and only reloaded on a handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            rd_bank_q    <= 1'b0;
            rd_idx_q     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_frame_id <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (full_q[rd_bank_q]) begin
                        state_q      <= StStream;
                        rd_idx_q     <= '0;
                        out_valid    <= 1'b1;
                        out_data     <= rd_word;
                        out_last     <= (LAST_RD == '0);
                        out_frame_id <= bank_id_q[rd_bank_q];
                    end
                end
                StStream: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd_bank_q <= ~rd_bank_q;
                            rd_idx_q  <= '0;
                        end else begin
                            rd_idx_q <= rd_sel;
                            out_data <= rd_word;
                            out_last <= (rd_sel == LAST_RD);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    a_hold_when_stalled: assert property (@(posedge clk) disable iff (!rst)
        out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_last)
                                    && $stable(out_frame_id));

    a_last_needs_valid: assert property (@(posedge clk) disable iff (!rst)
        out_last |-> out_valid);

endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Directed bench for mfcc_frame_buffer: vector table plus hand-written reset/overflow/latency runs.
module tb_mfcc_frame_buffer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 8;
`ifdef MFCC_DELTA_EN
    localparam int FLEN = 2 * N;
`else
    localparam int FLEN = N;
`endif

    typedef logic [N-1:0][W-1:0] frame_t;
    typedef struct packed {
        frame_t        c;
        frame_t        d;
        logic [IW-1:0] id;
        logic          stall;
    } vec_t;
    typedef struct {
        logic [W-1:0]  data;
        logic          last;
        logic [IW-1:0] id;
        int            cyc;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  mfcc_in;
    logic          valid_in;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [IW-1:0] out_frame_id;
    logic          overflow;
    logic          clear_ovf;

    mfcc_frame_buffer #(
        .NUM_COEFFS    (N),
        .DATA_WIDTH    (W),
        .FRAME_ID_WIDTH(IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mfcc_in     (mfcc_in),
        .valid_in    (valid_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_frame_id(out_frame_id),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    always #5 clk = ~clk;

    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    bit      rand_ready = 1'b0;
    word_t   got_q[$];
    bit      stalled = 1'b0;
    logic [W-1:0]  h_data;
    logic          h_last;
    logic [IW-1:0] h_id;
    vec_t    vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshakes are recorded at the falling edge; stalled outputs must not move
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall valid", 32'(out_valid), 32'd1);
                chk("stall data", 32'(out_data), 32'(h_data));
                chk("stall last", 32'(out_last), 32'(h_last));
                chk("stall id", 32'(out_frame_id), 32'(h_id));
            end
            if (out_valid && out_ready) begin
                got_q.push_back('{data: out_data, last: out_last, id: out_frame_id, cyc: cyc});
            end
            stalled = out_valid && !out_ready;
            h_data  = out_data;
            h_last  = out_last;
            h_id    = out_frame_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < N; i++) begin
            valid_in = 1'b1;
            mfcc_in  = f[i];
            tick();
        end
        valid_in = 1'b0;
        mfcc_in  = '0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) tick();
        rst = 1'b1;
        got_q.delete();
    endtask

    task automatic wait_words(input string name, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({name, " word count"}, 32'(got_q.size()), 32'(n));
    endtask

    task automatic check_frame(input string name, input frame_t s, input frame_t d,
                               input logic [IW-1:0] id, input bit chk_d);
        if (got_q.size() < FLEN) begin
            chk({name, " length"}, 32'(got_q.size()), 32'(FLEN));
            got_q.delete();
            return;
        end
        for (int i = 0; i < FLEN; i++) begin
            word_t w;
            w = got_q.pop_front();
            if (i < N) chk($sformatf("%s word%0d", name, i), 32'(w.data), 32'(s[i]));
            else if (chk_d) chk($sformatf("%s delta%0d", name, i - N), 32'(w.data),
                                32'(d[i-N]));
            chk($sformatf("%s last%0d", name, i), 32'(w.last), 32'(i == FLEN - 1));
            chk($sformatf("%s id%0d", name, i), 32'(w.id), 32'(id));
        end
    endtask

    function automatic frame_t fr(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, input logic [W-1:0] d);
        fr = {d, c, b, a};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        frame_t p0, p1, p2, p3;
        vecs[0] = '{c: fr(16'h0064, 16'hFFCE, 16'h0000, 16'h7FFF),
                    d: fr(16'h0064, 16'hFFCE, 16'h0000, 16'h7FFF), id: 8'd0, stall: 1'b0};
        vecs[1] = '{c: fr(16'h0028, 16'hFFCE, 16'h0005, 16'h8000),
                    d: fr(16'hFFC4, 16'h0000, 16'h0005, 16'h8000), id: 8'd1, stall: 1'b0};
        vecs[2] = '{c: fr(16'h0001, 16'h0002, 16'h0003, 16'h0004),
                    d: fr(16'hFFD9, 16'h0034, 16'hFFFE, 16'h7FFF), id: 8'd2, stall: 1'b1};
        vecs[3] = '{c: fr(16'h8000, 16'h7FFF, 16'h0007, 16'hFFFF),
                    d: fr(16'h8000, 16'h7FFD, 16'h0004, 16'hFFFB), id: 8'd3, stall: 1'b1};
        p0 = fr(16'h0101, 16'h0102, 16'h0103, 16'h0104);
        p1 = fr(16'h0201, 16'h0202, 16'h0203, 16'h0204);
        p2 = fr(16'h0301, 16'h0302, 16'h0303, 16'h0304);
        p3 = fr(16'h0401, 16'h0402, 16'h0403, 16'h0404);

        rst = 1'b0; valid_in = 1'b0; mfcc_in = '0; out_ready = 1'b0; clear_ovf = 1'b0;

        // Reset with valid_in pulsing
        for (int i = 0; i < 3; i++) begin
            valid_in = ~valid_in;
            mfcc_in  = 16'h1234 + 16'(i);
            tick();
        end
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset out_frame_id", 32'(out_frame_id), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b1; valid_in = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        chk("post-reset words", 32'(got_q.size()), 32'd0);

        // Vector table: prev starts at zero, each frame fully drained before the next
        for (int k = 0; k < 4; k++) begin
            rand_ready = vecs[k].stall;
            out_ready  = 1'b1;
            send_frame(vecs[k].c);
            wait_words($sformatf("vec%0d", k), FLEN, 300);
            rand_ready = 1'b0;
            out_ready  = 1'b1;
            check_frame($sformatf("vec%0d", k), vecs[k].c, vecs[k].d, vecs[k].id, 1'b1);
        end

        // Mid-frame reset with one frame buffered and stalled
        out_ready = 1'b0;
        send_frame(fr(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD));
        repeat (3) tick();
        chk("buffered out_valid", 32'(out_valid), 32'd1);
        valid_in = 1'b1; mfcc_in = 16'h1111; tick();
        mfcc_in = 16'h2222; tick();
        valid_in = 1'b0; mfcc_in = '0;
        do_reset(2);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        repeat (10) tick();
        chk("midrst stale words", 32'(got_q.size()), 32'd0);

        // Single frame latency, first frame after reset carries ID 0
        for (int i = 0; i < N; i++) begin
            valid_in = 1'b1;
            mfcc_in  = 16'(16 * (i + 1));
            tick();
        end
        valid_in = 1'b0; mfcc_in = '0;
        chk("latency edge0 valid", 32'(out_valid), 32'd0);
        tick();
        chk("latency edge1 valid", 32'(out_valid), 32'd0);
        tick();
        chk("latency edge2 valid", 32'(out_valid), 32'd1);
        chk("latency edge2 data", 32'(out_data), 32'h10);
        chk("latency edge2 id", 32'(out_frame_id), 32'd0);
        wait_words("single", FLEN, 50);
        check_frame("single", fr(16'h10, 16'h20, 16'h30, 16'h40),
                    fr(16'h10, 16'h20, 16'h30, 16'h40), 8'd0, 1'b1);

        // Overflow: third frame dropped while both banks are held
        do_reset(2);
        out_ready = 1'b0;
        send_frame(p0);
        send_frame(p1);
        send_frame(p2);
        repeat (3) tick();
        chk("ovf flag set", 32'(overflow), 32'd1);
        chk("ovf no words while stalled", 32'(got_q.size()), 32'd0);
        out_ready = 1'b1;
        wait_words("ovf pair", 2 * FLEN, 100);
        if (got_q.size() >= 2 * FLEN) begin
            chk("back-to-back gap", 32'(got_q[FLEN].cyc - got_q[FLEN-1].cyc), 32'd2);
        end
        check_frame("ovf f0", p0, p0, 8'd0, 1'b1);
        check_frame("ovf f1", p1, fr(16'h0100, 16'h0100, 16'h0100, 16'h0100), 8'd1, 1'b1);
        chk("ovf sticky", 32'(overflow), 32'd1);
        send_frame(p3);
        wait_words("ovf f3", FLEN, 50);
        check_frame("ovf f3", p3, fr(16'h0200, 16'h0200, 16'h0200, 16'h0200), 8'd3, 1'b1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf cleared", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
